// File: rtl/vga_line_fetch.sv
// Ping-pong line prefetcher feeding the VGA timing controller: one bank is displayed
// while the next visible line is read from the framebuffer into the other bank.
module vga_line_fetch #(
  parameter int PIXELS_H = 640,
  parameter int PIXELS_V = 480,
  parameter int SIZE_H   = 799,
  parameter int SIZE_V   = 524,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic [ADDR_W-1:0] fb_base,
  output logic [11:0]       color,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [11:0]       mem_rd_data,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [9:0]        PIX_H      = 10'(PIXELS_H);
  localparam logic [9:0]        PIX_V      = 10'(PIXELS_V);
  localparam logic [9:0]        LAST_Y     = 10'(SIZE_V);
  localparam logic [9:0]        LAST_X     = 10'(PIXELS_H - 1);
  localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(PIXELS_H);

  if (PIXELS_H > SIZE_H || PIXELS_V > SIZE_V) begin : g_bad_geometry
    $error("visible area larger than raster");
  end

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_nxt;
  logic [11:0]       bank0 [PIXELS_H];
  logic [11:0]       bank1 [PIXELS_H];
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_nxt;
  logic [ADDR_W-1:0] start_addr;
  logic [9:0]        next_line;
  logic [9:0]        fetch_x;
  logic              fetch_bank;
  logic              trig;
  logic              start;
  logic              last_word;
  logic              ack_req;
  logic              visible;

  assign trig       = (px == 10'd0);
  assign next_line  = (py == LAST_Y) ? 10'd0 : py + 10'd1;
  assign start      = trig && (next_line < PIX_V);
  assign last_word  = (fetch_x == LAST_X);
  assign ack_req    = mem_rd_ack && (state == REQ);
  // A new frame's base must already apply to line 0's first address.
  assign base_nxt   = (next_line == 10'd0) ? fb_base : base;
  assign start_addr = base_nxt + ADDR_W'(next_line) * LINE_WORDS;
  assign visible    = (px < PIX_H) && (py < PIX_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (trig)                        state_nxt = start ? REQ : IDLE;
        else if (mem_rd_ack && last_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_req = (state == REQ);
  end

  // Fetch datapath: a trigger always restarts from x=0, even mid-line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base        <= '0;
      fetch_x     <= '0;
      fetch_bank  <= 1'b0;
      mem_rd_addr <= '0;
    end else if (start) begin
      base        <= base_nxt;
      fetch_x     <= '0;
      fetch_bank  <= next_line[0];
      mem_rd_addr <= start_addr;
    end else if (ack_req && !trig && !last_word) begin
      fetch_x     <= fetch_x + 10'd1;
      mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ack_req) begin
      if (fetch_bank) bank1[fetch_x] <= mem_rd_data;
      else            bank0[fetch_x] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  underrun <= 1'b0;
    else if (trig && state == REQ) underrun <= 1'b1;
    else if (underrun_clr)         underrun <= 1'b0;
  end

  // Display stage: one cycle from px/py to color.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     color <= 12'h000;
    else if (visible) color <= py[0] ? bank1[px] : bank0[px];
    else              color <= 12'h000;
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: the raster driver queues expected read addresses
// and pixel colours, and a negedge monitor compares them as the DUT produces them.
module tb_vga_line_fetch;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [9:0]    px = 10'd0;
  logic [9:0]    py = 10'd524;
  logic [AW-1:0] fb_base = '0;
  logic [11:0]   color;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack;
  logic [11:0]   mem_rd_data;
  logic          underrun;
  logic          underrun_clr = 1'b0;

  int            mem_mode = 2;
  logic [1:0]    slow_cnt = 2'd0;
  logic          tog_ack = 1'b0;

  int            checks = 0;
  int            errors = 0;
  int            req_cnt = 0;
  bit            sb_en = 1'b0;
  bit            col_chk = 1'b0;
  bit            col_chk_d = 1'b0;
  logic [AW-1:0] exp_addr[$];
  logic [11:0]   exp_col[$];
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] line_start[2];

  vga_line_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .px           (px),
    .py           (py),
    .fb_base      (fb_base),
    .color        (color),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  // Memory model: 0 = zero latency, 1 = ack on the third cycle of each word, 2 = free-running toggle.
  assign mem_rd_ack  = (mem_mode == 0) ? mem_rd_req :
                       (mem_mode == 1) ? (mem_rd_req && slow_cnt == 2'd2) : tog_ack;
  assign mem_rd_data = mem_rd_addr[11:0];

  always @(posedge clk) begin
    tog_ack   <= ~tog_ack;
    col_chk_d <= col_chk;
    if (!mem_rd_req || mem_rd_ack) slow_cnt <= 2'd0;
    else                           slow_cnt <= slow_cnt + 2'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_color(input int x, input int y);
    logic [AW-1:0] a;
    if (x < 640 && y < 480) begin
      a = line_start[y % 2] + AW'(x);
      return a[11:0];
    end
    return 12'h000;
  endfunction

  task automatic model_fetch(input int y);
    int n;
    logic [AW-1:0] s;
    n = (y == 524) ? 0 : y + 1;
    if (n < 480) begin
      if (n == 0) m_base = fb_base;
      s = m_base + AW'(n * 640);
      line_start[n % 2] = s;
      if (sb_en)
        for (int k = 0; k < 640; k++) exp_addr.push_back(s + AW'(k));
    end
  endtask

  // Drives n consecutive raster positions starting at (x0,y0); colours at px==ca/cb are scored.
  task automatic raster(input int x0, input int y0, input int n, input int ca, input int cb);
    int x;
    int y;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      px = 10'(x);
      py = 10'(y);
      if (x == ca || x == cb) begin
        exp_col.push_back(exp_color(x, y));
        col_chk = 1'b1;
      end else begin
        col_chk = 1'b0;
      end
      if (x == 0) model_fetch(y);
      @(posedge clk);
      #1;
      x++;
      if (x > 799) begin
        x = 0;
        y = (y == 524) ? 0 : y + 1;
      end
    end
    col_chk = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [11:0]   ec;
    if (mem_rd_req) req_cnt <= req_cnt + 1;
    if (sb_en && mem_rd_req && mem_rd_ack) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_addr_extra: got %0h expected no request", mem_rd_addr);
      end else begin
        ea = exp_addr.pop_front();
        check("rd_addr", 32'(mem_rd_addr), 32'(ea));
      end
    end
    if (col_chk_d) begin
      if (exp_col.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL color_extra: got %0h expected nothing queued", color);
      end else begin
        ec = exp_col.pop_front();
        check("color", 32'(color), 32'(ec));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset with the memory ack toggling.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_color", 32'(color), 32'h0);
    check("rst_req", 32'(mem_rd_req), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_addr", 32'(mem_rd_addr), 32'h0);
    mem_mode = 0;
    sb_en    = 1'b1;
    reset_n  = 1'b1;
    raster(0, 524, 1, -1, -1);
    @(negedge clk);
    check("start_req", 32'(mem_rd_req), 32'h1);
    check("start_addr", 32'(mem_rd_addr), 32'(fb_base));
    raster(1, 524, 799, -1, -1);
    check("line0_req_cycles", 32'(req_cnt), 32'd640);

    // Zero-latency display of lines 0 and 1.
    raster(0, 0, 800, 5, 639);
    raster(0, 1, 800, 639, 700);

    // Last visible line and vertical blanking.
    raster(0, 478, 800, -1, -1);
    c0 = req_cnt;
    raster(0, 479, 800, 5, -1);
    check("no_fetch_line480", 32'(req_cnt), 32'(c0));
    raster(0, 490, 20, 10, -1);
    check("sb_drained_b", 32'(exp_addr.size()), 32'd0);

    // Slow memory: fetch overruns its line.
    sb_en    = 1'b0;
    mem_mode = 1;
    raster(0, 10, 800, -1, -1);
    @(negedge clk);
    check("slow_underrun_before", 32'(underrun), 32'h0);
    check("slow_req_busy", 32'(mem_rd_req), 32'h1);
    raster(0, 11, 1, -1, -1);
    @(negedge clk);
    check("underrun_set", 32'(underrun), 32'h1);
    check("restart_addr_l12", 32'(mem_rd_addr), 32'h1E00);
    check("restart_req", 32'(mem_rd_req), 32'h1);
    raster(1, 11, 99, -1, -1);
    underrun_clr = 1'b1;
    raster(100, 11, 1, -1, -1);
    underrun_clr = 1'b0;
    @(negedge clk);
    check("underrun_clr", 32'(underrun), 32'h0);
    raster(101, 11, 699, -1, -1);
    underrun_clr = 1'b1;
    raster(0, 12, 1, -1, -1);
    underrun_clr = 1'b0;
    @(negedge clk);
    check("underrun_set_wins", 32'(underrun), 32'h1);
    check("restart_addr_l13", 32'(mem_rd_addr), 32'h2080);
    mem_mode = 0;
    raster(1, 12, 799, -1, -1);

    // Base change mid-frame takes effect only at line 0.
    fb_base      = 19'h10000;
    sb_en        = 1'b1;
    underrun_clr = 1'b1;
    raster(0, 100, 1, -1, -1);
    underrun_clr = 1'b0;
    @(negedge clk);
    check("underrun_clr_idle", 32'(underrun), 32'h0);
    raster(1, 100, 799, -1, -1);
    raster(0, 101, 800, 3, -1);
    raster(0, 524, 1, -1, -1);
    @(negedge clk);
    check("new_base_addr", 32'(mem_rd_addr), 32'h10000);
    raster(1, 524, 799, -1, -1);
    raster(0, 0, 800, 17, -1);

    // Address wrap at the top of the framebuffer space.
    fb_base = 19'h7FFF6;
    c0 = req_cnt;
    raster(0, 524, 800, -1, -1);
    check("wrap_no_stall", 32'(req_cnt - c0), 32'd640);
    raster(0, 0, 800, 9, 12);

    repeat (3) @(negedge clk);
    check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("color_queue_empty", 32'(exp_col.size()), 32'd0);
    check("final_underrun", 32'(underrun), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
